sm_subtractor_pipe: RTL and testbench



---
 rtl/sm_pkg.sv | 22 ++
 rtl/sm_addsub_core.sv | 44 ++++
 rtl/sm_subtractor_pipe.sv | 107 ++++++++++
 tb/tb_sm_subtractor_pipe.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sm_pkg.sv
// rtl/sm_pkg.sv - shared sign-magnitude word definitions
package sm_pkg;

    localparam int DATA_W = 12;
    localparam int MAG_W  = DATA_W - 1;
    localparam logic [MAG_W-1:0] SM_MAX_MAG = {MAG_W{1'b1}};

    typedef struct packed {
        logic             sign;
        logic [MAG_W-1:0] mag;
    } sm_word_t;

    function automatic sm_word_t sm_norm_zero(input sm_word_t w);
        sm_word_t r;
        r = w;
        if (w.mag == '0) begin
            r.sign = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/sm_addsub_core.sv
// rtl/sm_addsub_core.sv - combinational magnitude add/subtract with sign select
module sm_addsub_core
    import sm_pkg::*;
#(
    parameter int MAG_W    = sm_pkg::MAG_W,
    parameter int SATURATE = 1
) (
    input  logic             op_add,
    input  logic             sign1,
    input  logic             sign2,
    input  logic             mag1_ge,
    input  logic [MAG_W-1:0] mag1,
    input  logic [MAG_W-1:0] mag2,
    output logic             res_sign,
    output logic [MAG_W-1:0] res_mag,
    output logic             carry
);

    logic [MAG_W:0]   sum;
    logic [MAG_W-1:0] mag_sel;
    logic             sign_sel;

    always_comb begin
        sum      = {1'b0, mag1} + {1'b0, mag2};
        carry    = 1'b0;
        mag_sel  = '0;
        sign_sel = 1'b0;
        if (op_add) begin
            sign_sel = sign1;
            carry    = sum[MAG_W];
            mag_sel  = (carry && (SATURATE != 0)) ? {MAG_W{1'b1}} : sum[MAG_W-1:0];
        end else if (mag1_ge) begin
            sign_sel = sign1;
            mag_sel  = mag1 - mag2;
        end else begin
            sign_sel = sign2;
            mag_sel  = mag2 - mag1;
        end
        // A zero magnitude (equal operands or a wrapped carry) is always +0
        res_mag  = mag_sel;
        res_sign = sign_sel & (|mag_sel);
    end

endmodule

// File: rtl/sm_subtractor_pipe.sv
// rtl/sm_subtractor_pipe.sv - two-stage pipelined sign-magnitude subtractor
module sm_subtractor_pipe
    import sm_pkg::*;
#(
    parameter int DATA_W   = sm_pkg::DATA_W,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out,
    output logic              ovf
);

    localparam int MW = DATA_W - 1;

    logic          s1_valid;
    logic          s1_sign1;
    logic          s1_sign2;
    logic [MW-1:0] s1_mag1;
    logic [MW-1:0] s1_mag2;
    logic          s1_add;
    logic          s1_ge;

    logic          s2_load;
    logic          in_xfer;

    logic [MW-1:0] a_mag;
    logic [MW-1:0] b_mag;
    logic          a_sign;
    logic          b_sign_eff;

    logic          core_sign;
    logic [MW-1:0] core_mag;
    logic          core_carry;

    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign in_xfer  = in_valid && in_ready;

    // Negative zero collapses to +0 before the subtrahend sign is flipped
    assign a_mag      = in1[MW-1:0];
    assign b_mag      = in2[MW-1:0];
    assign a_sign     = in1[DATA_W-1] & (|a_mag);
    assign b_sign_eff = ~(in2[DATA_W-1] & (|b_mag));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign1 <= 1'b0;
            s1_sign2 <= 1'b0;
            s1_mag1  <= '0;
            s1_mag2  <= '0;
            s1_add   <= 1'b0;
            s1_ge    <= 1'b0;
        end else begin
            if (in_xfer) begin
                s1_valid <= 1'b1;
                s1_sign1 <= a_sign;
                s1_sign2 <= b_sign_eff;
                s1_mag1  <= a_mag;
                s1_mag2  <= b_mag;
                s1_add   <= (a_sign == b_sign_eff);
                s1_ge    <= (a_mag >= b_mag);
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    sm_addsub_core #(
        .MAG_W    (MW),
        .SATURATE (SATURATE)
    ) u_core (
        .op_add   (s1_add),
        .sign1    (s1_sign1),
        .sign2    (s1_sign2),
        .mag1_ge  (s1_ge),
        .mag1     (s1_mag1),
        .mag2     (s1_mag2),
        .res_sign (core_sign),
        .res_mag  (core_mag),
        .carry    (core_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            ovf       <= 1'b0;
        end else begin
            if (s2_load) begin
                out_valid <= 1'b1;
                out       <= {core_sign, core_mag};
                ovf       <= core_carry;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sm_subtractor_pipe.sv
// tb/tb_sm_subtractor_pipe.sv - directed vector bench for sm_subtractor_pipe
module tb_sm_subtractor_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [11:0] in1;
    logic [11:0] in2;
    logic        in_ready,  in_ready_w;
    logic        out_valid, out_valid_w;
    logic [11:0] out_s,     out_w;
    logic        ovf_s,     ovf_w;

    int n_checks = 0;
    int n_fail   = 0;

    sm_subtractor_pipe #(.DATA_W(12), .SATURATE(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
        .out(out_s), .ovf(ovf_s)
    );

    sm_subtractor_pipe #(.DATA_W(12), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .in1(in1), .in2(in2), .out_valid(out_valid_w), .out_ready(out_ready),
        .out(out_w), .ovf(ovf_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic [11:0] exp_sat;
        logic [11:0] exp_wrap;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[14];

    logic [11:0] bp_a[5];
    logic [11:0] bp_b[5];
    logic [11:0] bp_exp[5];
    logic [11:0] rx[$];
    logic [11:0] hold_val;

    initial begin
        //          a       b       sat     wrap    ovf
        vecs[0]  = '{12'h005, 12'h003, 12'h002, 12'h002, 1'b0};
        vecs[1]  = '{12'h003, 12'h005, 12'h802, 12'h802, 1'b0};
        vecs[2]  = '{12'h805, 12'h003, 12'h808, 12'h808, 1'b0};
        vecs[3]  = '{12'h005, 12'h803, 12'h008, 12'h008, 1'b0};
        vecs[4]  = '{12'h7D0, 12'h864, 12'h7FF, 12'h034, 1'b1};
        vecs[5]  = '{12'h007, 12'h007, 12'h000, 12'h000, 1'b0};
        vecs[6]  = '{12'h800, 12'h000, 12'h000, 12'h000, 1'b0};
        vecs[7]  = '{12'h805, 12'h805, 12'h000, 12'h000, 1'b0};
        vecs[8]  = '{12'h7FF, 12'h801, 12'h7FF, 12'h000, 1'b1};
        vecs[9]  = '{12'h801, 12'h7FF, 12'hFFF, 12'h000, 1'b1};
        vecs[10] = '{12'h000, 12'h001, 12'h801, 12'h801, 1'b0};
        vecs[11] = '{12'h3FF, 12'h800, 12'h3FF, 12'h3FF, 1'b0};
        vecs[12] = '{12'h800, 12'h800, 12'h000, 12'h000, 1'b0};
        vecs[13] = '{12'h7FF, 12'hFFF, 12'h7FF, 12'h7FE, 1'b1};

        bp_a = '{12'h00A, 12'h001, 12'h810, 12'h020, 12'h100};
        bp_b = '{12'h001, 12'h00A, 12'h005, 12'h820, 12'h100};
        bp_exp = '{12'h009, 12'h809, 12'h815, 12'h040, 12'h000};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in1 = '0; in2 = '0;
        #12;
        check("rst out_valid", {31'b0, out_valid}, 32'd0);
        check("rst out", {20'b0, out_s}, 32'd0);
        check("rst ovf", {31'b0, ovf_s}, 32'd0);
        check("rst out_valid wrap", {31'b0, out_valid_w}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("in_ready after reset", {31'b0, in_ready}, 32'd1);

        // Table vectors, one at a time, with bubbles between them
        for (int i = 0; i < 14; i++) begin
            in1 = vecs[i].a; in2 = vecs[i].b; in_valid = 1'b1;
            #1;
            check($sformatf("v%0d in_ready", i), {31'b0, in_ready}, 32'd1);
            tick();
            in_valid = 1'b0; in1 = 12'hABC; in2 = 12'h123;
            check($sformatf("v%0d early", i), {31'b0, out_valid}, 32'd0);
            tick();
            check($sformatf("v%0d out_valid", i), {31'b0, out_valid}, 32'd1);
            check($sformatf("v%0d out sat", i), {20'b0, out_s}, {20'b0, vecs[i].exp_sat});
            check($sformatf("v%0d ovf sat", i), {31'b0, ovf_s}, {31'b0, vecs[i].exp_ovf});
            check($sformatf("v%0d out wrap", i), {20'b0, out_w}, {20'b0, vecs[i].exp_wrap});
            check($sformatf("v%0d ovf wrap", i), {31'b0, ovf_w}, {31'b0, vecs[i].exp_ovf});
        end
        tick();
        check("idle out_valid", {31'b0, out_valid}, 32'd0);

        // Backpressure: 5 pairs, out_ready low for the first 4 cycles
        begin
            int idx;
            logic acc;
            idx = 0;
            rx.delete();
            for (int c = 0; c < 40; c++) begin
                out_ready = (c >= 4);
                if (idx < 5) begin
                    in_valid = 1'b1; in1 = bp_a[idx]; in2 = bp_b[idx];
                end else begin
                    in_valid = 1'b0;
                end
                #1;
                acc = in_valid && in_ready;
                if (c == 2) begin
                    hold_val = out_s;
                    check("bp in_ready c2", {31'b0, in_ready}, 32'd0);
                    check("bp accepts c2", idx, 2);
                end
                if (c == 3) begin
                    check("bp in_ready c3", {31'b0, in_ready}, 32'd0);
                    check("bp hold out", {20'b0, out_s}, {20'b0, hold_val});
                    check("bp hold value", {20'b0, out_s}, {20'b0, bp_exp[0]});
                    check("bp hold valid", {31'b0, out_valid}, 32'd1);
                end
                if (out_valid && out_ready) rx.push_back(out_s);
                tick();
                if (acc) idx++;
            end
            check("bp accepted", idx, 5);
            check("bp received", rx.size(), 5);
            for (int k = 0; k < 5; k++) begin
                if (k < rx.size())
                    check($sformatf("bp rx%0d", k), {20'b0, rx[k]}, {20'b0, bp_exp[k]});
            end
        end

        // Reset with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1; in1 = 12'h050; in2 = 12'h010;
        tick();
        in1 = 12'h060; in2 = 12'h010;
        tick();
        in_valid = 1'b0;
        tick();
        check("pre-rst out_valid", {31'b0, out_valid}, 32'd1);
        check("pre-rst in_ready", {31'b0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", {31'b0, out_valid}, 32'd0);
        check("async rst out", {20'b0, out_s}, 32'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check("post-rst idle", {31'b0, out_valid}, 32'd0);
        in_valid = 1'b1; in1 = 12'h009; in2 = 12'h004;
        tick();
        in_valid = 1'b0;
        check("post-rst early", {31'b0, out_valid}, 32'd0);
        tick();
        check("post-rst out_valid", {31'b0, out_valid}, 32'd1);
        check("post-rst out", {20'b0, out_s}, 32'h005);
        tick();
        check("post-rst drained", {31'b0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
